fft8_frame_sequencer: RTL and testbench

// Sequencer and stream adapter for the 8-point radix-2 FFT core (4 registered stages, write/start/ready).

---
 rtl/fft8_frame_sequencer_if.sv | 18 +
 rtl/fft8_frame_sequencer.sv | 107 ++++++++++
 tb/tb_fft8_frame_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fft8_frame_sequencer_if.sv
// fft8_frame_sequencer_if: sample stream, bin stream and FFT core bus
interface fft8_frame_sequencer_if #(parameter int DW = 16);
  logic s_valid, s_ready;
  logic signed [DW-1:0] s_real, s_imag;
  logic m_valid, m_ready, m_last;
  logic signed [DW-1:0] m_real, m_imag;
  logic [2:0] m_index;
  logic fft_write, fft_start, fft_ready;
  logic [8*DW-1:0] fft_in_real, fft_in_imag, fft_out_real, fft_out_imag;
  modport master (
    input s_valid, s_real, s_imag, m_ready, fft_ready, fft_out_real, fft_out_imag,
    output s_ready, m_valid, m_real, m_imag, m_index, m_last, fft_write, fft_start, fft_in_real, fft_in_imag
  );
  modport slave (
    output s_valid, s_real, s_imag, m_ready, fft_ready, fft_out_real, fft_out_imag,
    input s_ready, m_valid, m_real, m_imag, m_index, m_last, fft_write, fft_start, fft_in_real, fft_in_imag
  );
endinterface

// File: rtl/fft8_frame_sequencer.sv
// fft8_frame_sequencer: frames serial samples into the 8-point FFT core and streams the bins out
module fft8_frame_sequencer #(
  parameter int DW = 16,
  parameter int CORE_STAGES = 4,
  parameter int CNT_W = 16
) (
  input  logic CLK,
  input  logic RST,
  fft8_frame_sequencer_if.master bus,
  output logic busy,
  output logic [CNT_W-1:0] frame_count,
  output logic err_sync
);
  localparam int RW = $clog2(CORE_STAGES + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(CORE_STAGES - 1);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [3:0] in_count_q, in_count_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic [2:0] m_index_q, m_index_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic err_sync_q, err_sync_d;
  logic [8*DW-1:0] in_re_q, in_re_d, in_im_q, in_im_d, out_re_q, out_re_d, out_im_q, out_im_d;
  logic accept, drain_hs;
  assign bus.s_ready = !RST && !in_count_q[3];
  assign accept = bus.s_valid && bus.s_ready;
  assign bus.m_valid = state_q == DRAIN;
  assign drain_hs = bus.m_valid && bus.m_ready;
  assign bus.m_real = out_re_q[m_index_q*DW +: DW];
  assign bus.m_imag = out_im_q[m_index_q*DW +: DW];
  assign bus.m_index = m_index_q;
  assign bus.m_last = &m_index_q;
  assign bus.fft_write = state_q == LOAD;
  assign bus.fft_start = state_q == RUN;
  assign bus.fft_in_real = in_re_q;
  assign bus.fft_in_imag = in_im_q;
  assign busy = state_q != IDLE;
  assign frame_count = frame_count_q;
  assign err_sync = err_sync_q;
  always_comb begin
    state_d = state_q;
    in_count_d = in_count_q;
    run_cnt_d = '0;
    m_index_d = m_index_q;
    frame_count_d = frame_count_q;
    err_sync_d = err_sync_q;
    in_re_d = in_re_q;
    in_im_d = in_im_q;
    out_re_d = out_re_q;
    out_im_d = out_im_q;
    if (accept) begin
      in_re_d[in_count_q[2:0]*DW +: DW] = bus.s_real;
      in_im_d[in_count_q[2:0]*DW +: DW] = bus.s_imag;
      in_count_d = in_count_q + 4'd1;
    end
    case (state_q)
      IDLE: state_d = in_count_q[3] ? LOAD : IDLE;
      LOAD: begin
        in_count_d = '0;
        state_d = RUN;
      end
      RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        state_d = run_cnt_q == RUN_LAST ? CAPTURE : RUN;
      end
      CAPTURE: begin
        out_re_d = bus.fft_out_real;
        out_im_d = bus.fft_out_imag;
        err_sync_d = err_sync_q || !bus.fft_ready;
        state_d = DRAIN;
      end
      DRAIN: if (drain_hs) begin
        m_index_d = m_index_q + 3'd1;
        if (&m_index_q) begin
          frame_count_d = frame_count_q + 1'b1;
          state_d = in_count_q[3] ? LOAD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      in_count_q <= '0;
      run_cnt_q <= '0;
      m_index_q <= '0;
      frame_count_q <= '0;
      err_sync_q <= 1'b0;
      in_re_q <= '0;
      in_im_q <= '0;
      out_re_q <= '0;
      out_im_q <= '0;
    end else begin
      state_q <= state_d;
      in_count_q <= in_count_d;
      run_cnt_q <= run_cnt_d;
      m_index_q <= m_index_d;
      frame_count_q <= frame_count_d;
      err_sync_q <= err_sync_d;
      in_re_q <= in_re_d;
      in_im_q <= in_im_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
    end
  end
endmodule

// File: tb/tb_fft8_frame_sequencer.sv
// tb_fft8_frame_sequencer: directed scoreboard bench with a behavioural 4-stage FFT core
module tb_fft8_frame_sequencer;
  localparam int DW = 16;
  typedef struct { logic [2:0] idx; logic [15:0] re, im; } bin_t;
  logic CLK = 0, RST;
  logic busy, err_sync;
  logic [15:0] frame_count;
  int checks = 0, failures = 0, pops = 0, pops0, start_len = 0, write_len = 0, n;
  bit force_low = 0;
  bin_t q[$];
  logic [127:0] fr, fi, core_xr, core_xi;
  logic [15:0] base;
  int core_cnt;
  logic core_rdy;
  fft8_frame_sequencer_if #(.DW(DW)) bus ();
  fft8_frame_sequencer #(.DW(DW), .CORE_STAGES(4), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .busy(busy), .frame_count(frame_count), .err_sync(err_sync)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s", tag);
    end
  endtask
  function automatic int rnd(real r);
    return r >= 0.0 ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction
  function automatic logic [255:0] dft8(input logic [127:0] xr, input logic [127:0] xi);
    logic [127:0] yr, yi;
    real ar, ai, a, b, c, s;
    for (int k = 0; k < 8; k++) begin
      ar = 0.0;
      ai = 0.0;
      for (int m = 0; m < 8; m++) begin
        a = $itor($signed(xr[m*16 +: 16]));
        b = $itor($signed(xi[m*16 +: 16]));
        c = $cos(2.0 * 3.14159265358979 * k * m / 8.0);
        s = $sin(2.0 * 3.14159265358979 * k * m / 8.0);
        ar += a * c + b * s;
        ai += b * c - a * s;
      end
      yr[k*16 +: 16] = 16'(rnd(ar));
      yi[k*16 +: 16] = 16'(rnd(ai));
    end
    return {yr, yi};
  endfunction
  always @(posedge CLK) begin
    if (RST) begin
      core_cnt <= 0;
      core_rdy <= 1'b0;
      bus.fft_out_real <= '0;
      bus.fft_out_imag <= '0;
    end else if (bus.fft_write) begin
      core_xr <= bus.fft_in_real;
      core_xi <= bus.fft_in_imag;
      core_cnt <= 0;
      core_rdy <= 1'b0;
      bus.fft_out_real <= '0;
      bus.fft_out_imag <= '0;
    end else if (bus.fft_start) begin
      core_cnt <= (core_cnt + 1) % 4;
      if (core_cnt == 3) begin
        {bus.fft_out_real, bus.fft_out_imag} <= dft8(core_xr, core_xi);
        core_rdy <= 1'b1;
      end
    end
  end
  assign bus.fft_ready = core_rdy && !force_low;
  always @(negedge CLK) begin
    if (RST) begin
      start_len <= 0;
      write_len <= 0;
    end else begin
      start_len <= bus.fft_start ? start_len + 1 : 0;
      write_len <= bus.fft_write ? write_len + 1 : 0;
      if (!bus.fft_start && start_len != 0) begin
        chk("start_len", start_len === 4);
        chk("capture_ready", bus.fft_ready === !force_low);
      end
      if (!bus.fft_write && write_len != 0) chk("write_len", write_len === 1);
      if (bus.fft_write) chk("write_start_excl", bus.fft_start === 1'b0);
    end
  end
  always @(negedge CLK) begin
    if (!RST && bus.m_valid && bus.m_ready) begin
      bin_t e;
      pops++;
      if (q.size() == 0) chk("unexpected_bin", bus.m_index === 3'bx);
      else begin
        e = q.pop_front();
        chk("bin_index", bus.m_index === e.idx);
        chk("bin_real", bus.m_real === e.re);
        chk("bin_imag", bus.m_imag === e.im);
        chk("bin_last", bus.m_last === (e.idx == 3'd7));
      end
    end
  end
  task automatic send(input logic [15:0] r, input logic [15:0] i);
    bit ok = 0;
    bus.s_valid = 1'b1;
    bus.s_real = r;
    bus.s_imag = i;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge CLK);
      ok = bus.s_ready;
      @(posedge CLK);
    end
    #1;
    bus.s_valid = 1'b0;
    if (!ok) chk("s_timeout", ok === 1'b1);
  endtask
  task automatic send_frame(input logic [127:0] xr, input logic [127:0] xi);
    logic [255:0] y;
    for (int k = 0; k < 8; k++) send(xr[k*16 +: 16], xi[k*16 +: 16]);
    y = dft8(xr, xi);
    for (int k = 0; k < 8; k++) q.push_back('{3'(k), y[128 + k*16 +: 16], y[k*16 +: 16]});
  endtask
  task automatic rand_frame(output logic [127:0] xr, output logic [127:0] xi);
    for (int k = 0; k < 8; k++) begin
      xr[k*16 +: 16] = 16'(int'($urandom_range(0, 2000)) - 1000);
      xi[k*16 +: 16] = 16'(int'($urandom_range(0, 2000)) - 1000);
    end
  endtask
  task automatic wait_idle();
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge CLK);
      #1;
      done = !busy && q.size() == 0;
    end
    if (!done) chk("idle_timeout", done === 1'b1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    RST = 1;
    bus.s_valid = 0;
    bus.s_real = 0;
    bus.s_imag = 0;
    bus.m_ready = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_s_ready", bus.s_ready === 1'b0);
    chk("rst_m_valid", bus.m_valid === 1'b0);
    chk("rst_busy", busy === 1'b0);
    chk("rst_frame_count", frame_count === 16'd0);
    chk("rst_err_sync", err_sync === 1'b0);
    chk("rst_fft_write", bus.fft_write === 1'b0);
    chk("rst_fft_start", bus.fft_start === 1'b0);
    RST = 0;
    #1;
    chk("post_rst_s_ready", bus.s_ready === 1'b1);
    bus.m_ready = 1;
    fr = '0;
    fi = '0;
    fr[15:0] = 16'd256;
    send_frame(fr, fi);
    wait_idle();
    chk("impulse_frame_count", frame_count === 16'd1);
    chk("impulse_err_sync", err_sync === 1'b0);
    for (int k = 0; k < 8; k++) fr[k*16 +: 16] = 16'd100;
    send_frame(fr, fi);
    n = 0;
    while (!bus.m_valid && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("dc_latency", n === 7);
    wait_idle();
    chk("dc_frame_count", frame_count === 16'd2);
    base = frame_count;
    rand_frame(fr, fi);
    send_frame(fr, fi);
    n = 0;
    while (!(bus.m_valid && bus.m_index == 3'd3) && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    bus.m_ready = 0;
    rand_frame(fr, fi);
    send_frame(fr, fi);
    @(negedge CLK);
    chk("bp_s_ready_low", bus.s_ready === 1'b0);
    repeat (12) @(posedge CLK);
    #1;
    chk("bp_m_valid", bus.m_valid === 1'b1);
    chk("bp_index_held", bus.m_index === 3'd3);
    chk("bp_real_held", bus.m_real === q[0].re);
    chk("bp_imag_held", bus.m_imag === q[0].im);
    bus.m_ready = 1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(bus.m_valid && bus.m_last) && n < 50);
    @(posedge CLK);
    #1;
    chk("drain_to_load", bus.fft_write === 1'b1);
    wait_idle();
    chk("bp_frame_count", frame_count === 16'(base + 16'd2));
    force_low = 1;
    pops0 = pops;
    rand_frame(fr, fi);
    send_frame(fr, fi);
    wait_idle();
    chk("sync_err_set", err_sync === 1'b1);
    chk("sync_err_bins", (pops - pops0) === 8);
    force_low = 0;
    rand_frame(fr, fi);
    send_frame(fr, fi);
    wait_idle();
    chk("sync_err_sticky", err_sync === 1'b1);
    fr = '0;
    fi = '0;
    fr[15:0] = 16'd256;
    send_frame(fr, fi);
    n = 0;
    while (!bus.fft_start && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    @(posedge CLK);
    #1;
    RST = 1;
    q.delete();
    @(posedge CLK);
    #1;
    chk("rst_run_fft_start", bus.fft_start === 1'b0);
    chk("rst_run_m_valid", bus.m_valid === 1'b0);
    chk("rst_run_s_ready", bus.s_ready === 1'b0);
    RST = 0;
    #1;
    chk("rel_s_ready", bus.s_ready === 1'b1);
    chk("rel_fft_start", bus.fft_start === 1'b0);
    chk("rel_m_valid", bus.m_valid === 1'b0);
    chk("rel_err_sync", err_sync === 1'b0);
    chk("rel_frame_count", frame_count === 16'd0);
    send_frame(fr, fi);
    wait_idle();
    chk("rst_impulse_frame_count", frame_count === 16'd1);
    chk("rst_impulse_err_sync", err_sync === 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
